// File: rtl/sl_rx_apb_poller.sv
// APB master that polls the SL transceiver status register, fetches ready words
// and queues them in a small FIFO. Optional `SL_POLL_ERR_DROP_EN drops parity-error words.
module sl_rx_apb_poller #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [7:0]  STATUS_ADDR   = 8'h04,
  parameter logic [7:0]  DATA_ADDR     = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        poll_now,
  output logic [7:0]  paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  input  logic [31:0] prdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_len,
  output logic        out_perr,
  output logic        rx_stall,
  output logic [4:0]  fifo_level
`ifdef SL_POLL_ERR_DROP_EN
  ,
  output logic [7:0]  err_drop_cnt
`endif
);

  localparam int unsigned TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, S_SETUP, S_ACCESS, EVAL, D_SETUP, D_ACCESS, PUSH
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  len;
    logic        perr;
  } entry_t;

  state_t        state, next_state;
  logic [TW-1:0] timer, timer_next;
  logic [7:0]    paddr_next;
  logic          psel_next, penable_next;
  logic          st_ready, st_perr;
  logic [5:0]    st_len;
  logic [31:0]   rd_data;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, push, pop;

  assign pwrite    = 1'b0;
  assign fifo_full = (fifo_level == 5'(FIFO_DEPTH));
  assign out_valid = (fifo_level != 5'd0);
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.data : 32'd0;
  assign out_len   = out_valid ? head.len  : 6'd0;
  assign out_perr  = out_valid ? head.perr : 1'b0;

`ifdef SL_POLL_ERR_DROP_EN
  assign push = (state == PUSH) && !st_perr;
`else
  assign push = (state == PUSH);
`endif

  // Next state, poll timer and the bus phase the next state will drive
  always_comb begin
    next_state   = state;
    timer_next   = timer;
    psel_next    = 1'b0;
    penable_next = 1'b0;
    paddr_next   = 8'h00;
    case (state)
      IDLE: begin
        if (!enable) begin
          timer_next = '0;
        end else if (poll_now || (timer == TW'(POLL_INTERVAL - 1))) begin
          next_state = S_SETUP;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      S_SETUP:  next_state = S_ACCESS;
      S_ACCESS: next_state = EVAL;
      EVAL:     next_state = (st_ready && !fifo_full) ? D_SETUP : IDLE;
      D_SETUP:  next_state = D_ACCESS;
      D_ACCESS: next_state = PUSH;
      PUSH:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    case (next_state)
      S_SETUP:  begin psel_next = 1'b1; paddr_next = STATUS_ADDR; end
      S_ACCESS: begin psel_next = 1'b1; penable_next = 1'b1; paddr_next = STATUS_ADDR; end
      D_SETUP:  begin psel_next = 1'b1; paddr_next = DATA_ADDR; end
      D_ACCESS: begin psel_next = 1'b1; penable_next = 1'b1; paddr_next = DATA_ADDR; end
      default:  ;
    endcase
  end

  // State, bus outputs and captured register contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      paddr    <= 8'h00;
      psel     <= 1'b0;
      penable  <= 1'b0;
      st_ready <= 1'b0;
      st_perr  <= 1'b0;
      st_len   <= 6'd0;
      rd_data  <= 32'd0;
      rx_stall <= 1'b0;
    end else begin
      state   <= next_state;
      timer   <= timer_next;
      paddr   <= paddr_next;
      psel    <= psel_next;
      penable <= penable_next;
      if (state == S_ACCESS) begin
        st_ready <= prdata[0];
        st_perr  <= prdata[1];
        st_len   <= (prdata[13:8] == 6'd0) ? 6'd32 : prdata[13:8];
      end
      if (state == D_ACCESS) rd_data <= prdata;
      // A full FIFO leaves the word in the transceiver for the next poll
      if (state == EVAL) rx_stall <= st_ready && fifo_full;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + 5'(push) - 5'(pop);
    end
  end

  // Storage is not reset; outputs are gated by out_valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{data: rd_data, len: st_len, perr: st_perr};
  end

`ifdef SL_POLL_ERR_DROP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_drop_cnt <= 8'd0;
    end else if ((state == PUSH) && st_perr && (err_drop_cnt != 8'hFF)) begin
      err_drop_cnt <= err_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sl_rx_apb_poller.sv
// Bench for sl_rx_apb_poller: transceiver model, APB monitor, vector table,
// directed corner sequences and a randomized run against an in-order word scoreboard.
`timescale 1ns/1ps
module tb_sl_rx_apb_poller;

  localparam int unsigned DEPTH = 4;
`ifdef SL_POLL_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, poll_now = 1'b0, out_ready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic [7:0]  paddr;
  logic        psel, penable, pwrite, out_valid, out_perr, rx_stall;
  logic [31:0] out_data;
  logic [5:0]  out_len;
  logic [4:0]  fifo_level;
`ifdef SL_POLL_ERR_DROP_EN
  logic [7:0]  err_drop_cnt;
  int          n_perr = 0;
`endif

  int checks = 0, errors = 0;
  int n_status_rd = 0, n_data_rd = 0, proto_err = 0, empty_rd = 0;

  typedef struct {logic [31:0] status; logic [31:0] data;} word_t;
  typedef struct {logic [31:0] data; logic [5:0] len; logic perr;} exp_t;
  typedef struct {
    logic [31:0] status; logic [31:0] data; logic push;
    logic [31:0] exp_data; logic [5:0] exp_len; logic exp_perr;
  } vec_t;

  word_t      xq[$];
  exp_t       exp_q[$];
  logic [7:0] rd_log[$];
  logic       prev_setup = 1'b0, prev_access = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  always #5 clk = ~clk;

  sl_rx_apb_poller dut (
    .clk(clk), .reset(reset), .enable(enable), .poll_now(poll_now),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_perr(out_perr), .rx_stall(rx_stall), .fifo_level(fifo_level)
`ifdef SL_POLL_ERR_DROP_EN
    , .err_drop_cnt(err_drop_cnt)
`endif
  );

  // Transceiver register file: ACCESS-phase data, random garbage otherwise
  always @(negedge clk) begin
    if (psel && penable && paddr == 8'h04)      prdata <= (xq.size() > 0) ? xq[0].status : 32'h0;
    else if (psel && penable && paddr == 8'h08) prdata <= (xq.size() > 0) ? xq[0].data : 32'hDEAD_BEEF;
    else                                        prdata <= $urandom();
  end

  // APB monitor: protocol rules, read log, data read consumes the transceiver word
  always @(posedge clk) begin
    if (reset) begin
      prev_setup  <= 1'b0;
      prev_access <= 1'b0;
    end else begin
      if (pwrite !== 1'b0 || (penable && !psel) || (!psel && paddr != 8'h00) ||
          (prev_setup && !(psel && penable && paddr == prev_addr)) ||
          (prev_access && psel) || (psel && penable && !prev_setup))
        proto_err <= proto_err + 1;
      if (psel && penable) begin
        rd_log.push_back(paddr);
        if (paddr == 8'h04) n_status_rd <= n_status_rd + 1;
        if (paddr == 8'h08) begin
          n_data_rd <= n_data_rd + 1;
          if (xq.size() > 0) xq.delete(0);
          else empty_rd <= empty_rd + 1;
        end
      end
      prev_setup  <= psel && !penable;
      prev_access <= psel && penable;
      prev_addr   <= paddr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t expect_of(input word_t w);
    exp_t e;
    int   bc;
    bc     = int'(w.status[13:8]);
    e.data = w.data;
    e.len  = (bc == 0) ? 6'd32 : 6'(bc);
    e.perr = w.status[1];
    return e;
  endfunction

  task automatic inject(input word_t w);
    xq.push_back(w);
`ifdef SL_POLL_ERR_DROP_EN
    if (w.status[1]) n_perr++;
    else exp_q.push_back(expect_of(w));
`else
    exp_q.push_back(expect_of(w));
`endif
  endtask

  // One clock; a head pop at the coming edge is checked against the scoreboard
  task automatic tick();
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got word %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_len, out_perr} !== {e.data, e.len, e.perr}) begin
          errors++;
          $display("FAIL sb_word: got %0h/%0d/%0b expected %0h/%0d/%0b",
                   out_data, out_len, out_perr, e.data, e.len, e.perr);
        end
      end
    end
    @(negedge clk);
  endtask

  vec_t  vecs[5];
  word_t w;
  int    lat, d0, s0, n, k, bad, ov, r, bc;
  int    starts[$];

  initial begin
    vecs[0] = '{32'h0000_1001, 32'h0000_A5C3, 1'b1,  32'h0000_A5C3, 6'd16, 1'b0};
    vecs[1] = '{32'h0000_0003, 32'hFFFF_FFFF, !DROP, 32'hFFFF_FFFF, 6'd32, 1'b1};
    vecs[2] = '{32'h0000_0101, 32'h0000_0001, 1'b1,  32'h0000_0001, 6'd1,  1'b0};
    vecs[3] = '{32'h0000_1F03, 32'h7FFF_FFFF, !DROP, 32'h7FFF_FFFF, 6'd31, 1'b1};
    vecs[4] = '{32'hFFFF_C0FD, 32'h8000_0000, 1'b1,  32'h8000_0000, 6'd32, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_paddr", paddr, 0);      check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);  check("rst_pwrite", pwrite, 0);
    check("rst_out_valid", out_valid, 0); check("rst_out_data", out_data, 0);
    check("rst_out_len", out_len, 0);  check("rst_out_perr", out_perr, 0);
    check("rst_rx_stall", rx_stall, 0); check("rst_fifo_level", fifo_level, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Vector table: one word per forced poll
    for (int i = 0; i < 5; i++) begin
      rd_log.delete();
      d0 = n_data_rd; s0 = n_status_rd;
      inject('{vecs[i].status, vecs[i].data});
      enable = 1'b1; poll_now = 1'b1;
      tick();
      poll_now = 1'b0; lat = 1;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      if (vecs[i].push) begin
        check("vec_latency", lat, 7);
        check("vec_data", out_data, vecs[i].exp_data);
        check("vec_len", out_len, vecs[i].exp_len);
        check("vec_perr", out_perr, vecs[i].exp_perr);
        check("vec_level1", fifo_level, 1);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("vec_level0", fifo_level, 0);
      end else begin
        check("vec_dropped", out_valid, 0);
      end
      enable = 1'b0;
      repeat (3) tick();
      check("vec_status_rds", n_status_rd - s0, 1);
      check("vec_data_rds", n_data_rd - d0, 1);
      check("vec_rd_count", rd_log.size(), 2);
      if (rd_log.size() == 2) begin
        check("vec_rd0_addr", rd_log[0], 8'h04);
        check("vec_rd1_addr", rd_log[1], 8'h08);
      end
`ifdef SL_POLL_ERR_DROP_EN
      check("vec_drop_cnt", err_drop_cnt, n_perr);
`endif
    end

    // Idle polling with no ready word: status reads every 19 cycles
    starts.delete(); bad = 0; ov = 0; d0 = n_data_rd;
    enable = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (psel && !penable) begin
        if (paddr == 8'h04) starts.push_back(t);
        else bad++;
      end
      if (out_valid) ov++;
    end
    enable = 1'b0;
    repeat (4) tick();
    check("poll_count", starts.size(), 4);
    if (starts.size() >= 3) begin
      check("first_poll", starts[0], 16);
      check("poll_interval1", starts[1] - starts[0], 19);
      check("poll_interval2", starts[2] - starts[1], 19);
    end
    check("idle_no_data_setup", bad, 0);
    check("idle_no_data_read", n_data_rd - d0, 0);
    check("idle_no_valid", ov, 0);

    // FIFO full: stall, retry, refill after one pop
    d0 = n_data_rd;
    for (int i = 0; i < 5; i++) begin
      w.status = {18'h0, 6'(i + 4), 8'h01};
      w.data   = 32'hC0DE_0000 + 32'(i);
      inject(w);
    end
    out_ready = 1'b0; enable = 1'b1;
    n = 0; while (fifo_level != 5'd4 && n < 200) begin tick(); n++; end
    check("fill_level", fifo_level, 4);
    n = 0; while (!rx_stall && n < 40) begin tick(); n++; end
    check("stall_set", rx_stall, 1);
    check("stall_four_reads", n_data_rd - d0, 4);
    check("stall_word_left", xq.size(), 1);
    repeat (25) tick();
    check("stall_no_data_read", n_data_rd - d0, 4);
    check("stall_held", rx_stall, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("after_pop_level", fifo_level, 3);
    n = 0; while (fifo_level != 5'd4 && n < 40) begin tick(); n++; end
    check("refill_level", fifo_level, 4);
    check("refill_read", n_data_rd - d0, 5);
    check("refill_xcvr_empty", xq.size(), 0);
    check("refill_stall_clr", rx_stall, 0);
    out_ready = 1'b1; repeat (6) tick();
    out_ready = 1'b0; enable = 1'b0; repeat (3) tick();
    check("full_drained", fifo_level, 0);
    check("full_sb_empty", exp_q.size(), 0);

    // Reset during D_ACCESS with one word already queued
    inject('{32'h0000_0A01, 32'h1111_2222});
    enable = 1'b1; poll_now = 1'b1; tick(); poll_now = 1'b0;
    n = 0; while (!out_valid && n < 20) begin tick(); n++; end
    check("pre_rst_level", fifo_level, 1);
    inject('{32'h0000_0901, 32'h1234_5678});
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    n = 0; while (!(psel && penable && paddr == 8'h08) && n < 20) begin tick(); n++; end
    check("d_access_reached", {psel, penable, paddr}, {2'b11, 8'h08});
    reset = 1'b1;
    #1;
    check("midrst_psel", psel, 0);
    check("midrst_penable", penable, 0);
    check("midrst_paddr", paddr, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_valid", out_valid, 0);
    exp_q.delete(0);
    tick(); tick();
    check("midrst_word_kept", xq.size(), 1);
    reset = 1'b0;
    n = 0; while (!psel && n < 40) begin tick(); n++; end
    check("first_poll_after_rst", n, 16);
    n = 0; while (!out_valid && n < 20) begin tick(); n++; end
    out_ready = 1'b1; tick(); out_ready = 1'b0; enable = 1'b0;
    repeat (4) tick();
    check("rst_seq_sb_empty", exp_q.size(), 0);

    // poll_now ignored while disabled; honoured next cycle when enabled
    s0 = n_status_rd; k = 0;
    for (int t = 0; t < 30; t++) begin
      poll_now = (t % 7 == 3);
      tick();
      if (psel) k++;
    end
    poll_now = 1'b0;
    check("disabled_no_psel", k, 0);
    check("disabled_no_reads", n_status_rd - s0, 0);
    enable = 1'b1; poll_now = 1'b1; tick(); poll_now = 1'b0;
    check("poll_now_psel", psel, 1);
    check("poll_now_penable", penable, 0);
    check("poll_now_paddr", paddr, 8'h04);
    tick();
    check("poll_now_access", penable, 1);
    enable = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the in-order scoreboard
    for (int c = 0; c < 4000; c++) begin
      enable    = ($urandom_range(0, 15) != 0);
      poll_now  = ($urandom_range(0, 9) == 0);
      out_ready = (c % 500 < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      if ($urandom_range(0, 9) == 0 && xq.size() < 3) begin
        r  = int'($urandom());
        bc = int'($urandom_range(0, 31));
        w.status = (32'(r) & 32'hFFFF_C0FE) | {18'h0, 6'(bc), 8'h01};
        w.data   = $urandom();
        inject(w);
      end
      tick();
      checks++;
      if (out_valid !== (fifo_level != 5'd0) || fifo_level > 5'(DEPTH)) begin
        errors++;
        $display("FAIL rnd_level: got valid %0b level %0d expected valid==(level!=0) level<=%0d",
                 out_valid, fifo_level, DEPTH);
      end
    end
    enable = 1'b1; out_ready = 1'b1; poll_now = 1'b0;
    n = 0;
    while ((xq.size() != 0 || exp_q.size() != 0 || fifo_level != 5'd0) && n < 600) begin
      tick(); n++;
    end
    enable = 1'b0;
    repeat (4) tick();
    check("rnd_sb_empty", exp_q.size(), 0);
    check("rnd_xcvr_empty", xq.size(), 0);
`ifdef SL_POLL_ERR_DROP_EN
    check("rnd_drop_cnt", err_drop_cnt, (n_perr > 255) ? 255 : n_perr);
`endif
    check("apb_protocol", proto_err, 0);
    check("data_read_empty", empty_rd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
